// File: rtl/spi_cs_router.sv
// Command-addressed SPI chip-select router: one select byte picks a device,
// the frame closes after that device's bit count or on host CS# release.
module spi_cs_router #(
    parameter int                         NUM_DEV     = 4,
    parameter int                         SEL_BITS    = 8,
    parameter int                         CNT_W       = 6,
    parameter logic [NUM_DEV*CNT_W-1:0]   DEV_BITS    = {6'd24, 6'd24, 6'd32, 6'd32},
    parameter logic [NUM_DEV-1:0]         LDAC_MASK   = 4'b1100,
    parameter int                         LDAC_CYCLES = 4,
    parameter int                         SYNC_STAGES = 2
) (
    input  logic               clk_ref,
    input  logic               sys_rst,
    input  logic               host_csn,
    input  logic               host_sck,
    input  logic               host_sdi,
    output logic               host_sdo,
    output logic [NUM_DEV-1:0] dev_csn,
    output logic               dev_sck,
    output logic               dev_sdi,
    input  logic [NUM_DEV-1:0] dev_sdo,
    output logic [NUM_DEV-1:0] dev_ldacn,
    output logic               busy,
    output logic               sel_err,
    output logic               xfer_done,
    output logic [3:0]         cur_sel
);

    localparam int BW = $clog2(SEL_BITS + 1);
    localparam int LW = (LDAC_CYCLES > 1) ? $clog2(LDAC_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, CMD, DECODE, ACTIVE, LDAC, WAIT_CS, GAP
    } state_t;

    state_t state, state_d;

    logic [SYNC_STAGES-1:0] csn_s, sck_s, sdi_s;
    logic                   csn_hi, csn_fall, sck_rise, sdi_bit;

    logic [SEL_BITS-1:0] sel_sr, sel_sr_d;
    logic [BW-1:0]       bit_cnt, bit_cnt_d;
    logic [CNT_W-1:0]    pay_cnt, pay_cnt_d;
    logic [LW-1:0]       ldac_cnt, ldac_cnt_d;
    logic [3:0]          cur_sel_d;
    logic [NUM_DEV-1:0]  dev_csn_d, dev_ldacn_d;
    logic                sel_err_d, xfer_done_d;

    logic [NUM_DEV-1:0]  sel_oh, dec_oh;
    logic [CNT_W-1:0]    lim;
    logic [3:0]          dec_idx;

    // Sync flops clear to 0 so a CS# already low at release never looks like a fall
    always_ff @(posedge clk_ref or posedge sys_rst) begin
        if (sys_rst) begin
            csn_s <= '0;
            sck_s <= '0;
            sdi_s <= '0;
        end else begin
            csn_s <= {csn_s[SYNC_STAGES-2:0], host_csn};
            sck_s <= {sck_s[SYNC_STAGES-2:0], host_sck};
            sdi_s <= {sdi_s[SYNC_STAGES-2:0], host_sdi};
        end
    end

    assign csn_hi   = csn_s[SYNC_STAGES-2];
    assign csn_fall = ~csn_s[SYNC_STAGES-2] & csn_s[SYNC_STAGES-1];
    assign sck_rise = sck_s[SYNC_STAGES-2] & ~sck_s[SYNC_STAGES-1];
    assign sdi_bit  = sdi_s[SYNC_STAGES-2];

    always_comb begin
        sel_oh  = '0;
        dec_oh  = '0;
        lim     = '0;
        dec_idx = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            sel_oh[i] = (cur_sel == 4'(i));
            dec_oh[i] = (sel_sr == SEL_BITS'(i + 1));
            if (sel_oh[i]) lim = DEV_BITS[i*CNT_W +: CNT_W];
            if (dec_oh[i]) dec_idx = 4'(i);
        end
    end

    always_comb begin
        state_d     = state;
        sel_sr_d    = sel_sr;
        bit_cnt_d   = bit_cnt;
        pay_cnt_d   = pay_cnt;
        ldac_cnt_d  = ldac_cnt;
        cur_sel_d   = cur_sel;
        dev_csn_d   = dev_csn;
        dev_ldacn_d = dev_ldacn;
        sel_err_d   = 1'b0;
        xfer_done_d = 1'b0;
        unique case (state)
            IDLE: begin
                if (csn_fall) begin
                    sel_sr_d  = '0;
                    bit_cnt_d = '0;
                    state_d   = CMD;
                end
            end
            CMD: begin
                if (bit_cnt == BW'(SEL_BITS)) begin
                    state_d = DECODE;
                end else if (csn_hi) begin
                    state_d = IDLE;
                end else if (sck_rise) begin
                    sel_sr_d  = {sel_sr[SEL_BITS-2:0], sdi_bit};
                    bit_cnt_d = bit_cnt + 1'b1;
                end
            end
            DECODE: begin
                if (|dec_oh) begin
                    cur_sel_d = dec_idx;
                    dev_csn_d = ~dec_oh;
                    pay_cnt_d = '0;
                    state_d   = ACTIVE;
                end else begin
                    sel_err_d = 1'b1;
                    state_d   = WAIT_CS;
                end
            end
            ACTIVE: begin
                // Host release wins over a count match landing in the same cycle
                if (csn_hi || (lim != '0 && pay_cnt == lim)) begin
                    dev_csn_d   = '1;
                    xfer_done_d = 1'b1;
                    if (|(sel_oh & LDAC_MASK)) begin
                        dev_ldacn_d = ~sel_oh;
                        ldac_cnt_d  = '0;
                        state_d     = LDAC;
                    end else begin
                        state_d = csn_hi ? GAP : WAIT_CS;
                    end
                end else if (sck_rise && pay_cnt != '1) begin
                    pay_cnt_d = pay_cnt + 1'b1;
                end
            end
            LDAC: begin
                if (ldac_cnt == LW'(LDAC_CYCLES - 1)) begin
                    dev_ldacn_d = '1;
                    state_d     = csn_hi ? GAP : WAIT_CS;
                end else begin
                    ldac_cnt_d = ldac_cnt + 1'b1;
                end
            end
            WAIT_CS: begin
                if (csn_hi) state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_ref or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            sel_sr    <= '0;
            bit_cnt   <= '0;
            pay_cnt   <= '0;
            ldac_cnt  <= '0;
            cur_sel   <= '0;
            dev_csn   <= '1;
            dev_ldacn <= '1;
            sel_err   <= 1'b0;
            xfer_done <= 1'b0;
        end else begin
            state     <= state_d;
            sel_sr    <= sel_sr_d;
            bit_cnt   <= bit_cnt_d;
            pay_cnt   <= pay_cnt_d;
            ldac_cnt  <= ldac_cnt_d;
            cur_sel   <= cur_sel_d;
            dev_csn   <= dev_csn_d;
            dev_ldacn <= dev_ldacn_d;
            sel_err   <= sel_err_d;
            xfer_done <= xfer_done_d;
        end
    end

    assign dev_sck  = host_sck;
    assign dev_sdi  = host_sdi;
    assign busy     = (state != IDLE);
    assign host_sdo = (state == ACTIVE) && |(sel_oh & ~dev_csn) && |(sel_oh & dev_sdo);

endmodule

// File: tb/tb_spi_cs_router.sv
// Scoreboard bench for spi_cs_router: expected frames and LDAC pulses are
// queued by the stimulus and retired by a monitor watching the device side.
module tb_spi_cs_router;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       host_csn = 1'b1;
    logic       host_sck = 1'b0;
    logic       host_sdi = 1'b0;
    logic       host_sdo;
    logic [3:0] dev_csn;
    logic       dev_sck;
    logic       dev_sdi;
    logic [3:0] dev_sdo = 4'h0;
    logic [3:0] dev_ldacn;
    logic       busy;
    logic       sel_err;
    logic       xfer_done;
    logic [3:0] cur_sel;

    always #5 clk = ~clk;

    spi_cs_router dut (
        .clk_ref   (clk),
        .sys_rst   (sys_rst),
        .host_csn  (host_csn),
        .host_sck  (host_sck),
        .host_sdi  (host_sdi),
        .host_sdo  (host_sdo),
        .dev_csn   (dev_csn),
        .dev_sck   (dev_sck),
        .dev_sdi   (dev_sdi),
        .dev_sdo   (dev_sdo),
        .dev_ldacn (dev_ldacn),
        .busy      (busy),
        .sel_err   (sel_err),
        .xfer_done (xfer_done),
        .cur_sel   (cur_sel)
    );

    typedef struct {
        bit          is_err;
        int          dev;
        int          nbits;
        logic [63:0] data;
    } ev_t;

    typedef struct {
        int dev;
        int width;
    } ldac_t;

    ev_t   exp_q[$];
    ldac_t ldac_q[$];

    int tests = 0;
    int errors = 0;
    int onehot_viol = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor
    initial begin
        logic [3:0]  csn_prev = 4'hF;
        logic        sck_prev = 1'b0;
        int          edge_cnt = 0;
        int          frame_dev = -1;
        logic [63:0] data = '0;
        int          ldac_w = 0;
        int          ldac_dev = -1;
        ev_t         e;
        ldac_t       l;
        forever begin
            @(negedge clk);
            if (sys_rst) begin
                csn_prev = 4'hF;
                sck_prev = 1'b0;
                ldac_w   = 0;
            end else begin
                if ($countones(~dev_csn) > 1) onehot_viol++;
                if ($countones(~dev_ldacn) > 1) onehot_viol++;
                if (csn_prev == 4'hF && dev_csn != 4'hF) begin
                    edge_cnt = 0;
                    data = '0;
                    for (int i = 0; i < 4; i++)
                        if (!dev_csn[i]) frame_dev = i;
                end
                if (dev_csn != 4'hF && dev_sck && !sck_prev) begin
                    edge_cnt++;
                    data = {data[62:0], dev_sdi};
                end
                sck_prev = dev_sck;
                csn_prev = dev_csn;
                if (xfer_done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_xfer_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("xfer_kind", 0, 64'(e.is_err));
                        chk("xfer_cur_sel", 64'(cur_sel), 64'(e.dev));
                        chk("xfer_csn_dev", 64'(frame_dev), 64'(e.dev));
                        chk("xfer_edges", 64'(edge_cnt), 64'(e.nbits));
                        chk("xfer_data", data, e.data);
                        chk("xfer_csn_high", 64'(dev_csn), 64'hF);
                    end
                end
                if (sel_err) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_sel_err", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("err_kind", 1, 64'(e.is_err));
                        chk("err_csn", 64'(dev_csn), 64'hF);
                    end
                end
                if (dev_ldacn != 4'hF) begin
                    ldac_w++;
                    for (int i = 0; i < 4; i++)
                        if (!dev_ldacn[i]) ldac_dev = i;
                end else if (ldac_w > 0) begin
                    if (ldac_q.size() == 0) begin
                        chk("unexpected_ldac", 1, 0);
                    end else begin
                        l = ldac_q.pop_front();
                        chk("ldac_dev", 64'(ldac_dev), 64'(l.dev));
                        chk("ldac_width", 64'(ldac_w), 64'(l.width));
                    end
                    ldac_w = 0;
                end
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #2;
    endtask

    task automatic sck_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            host_sdi = v[i];
            #50;
            host_sck = 1'b1;
            #50;
            host_sck = 1'b0;
        end
    endtask

    task automatic frame_start();
        host_csn = 1'b0;
        #100;
    endtask

    task automatic frame_end();
        #50;
        host_csn = 1'b1;
        #200;
    endtask

    task automatic push_xfer(input int dev, input int n, input logic [63:0] d);
        ev_t e;
        e.is_err = 1'b0;
        e.dev    = dev;
        e.nbits  = n;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e.is_err = 1'b1;
        e.dev    = 0;
        e.nbits  = 0;
        e.data   = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_ldac(input int dev, input int w);
        ldac_t l;
        l.dev   = dev;
        l.width = w;
        ldac_q.push_back(l);
    endtask

    task automatic bad_code(input logic [7:0] code);
        bit ok;
        push_err();
        frame_start();
        sck_bits(64'(code), 8);
        sck_bits(64'hFF, 8);
        chk("bad_code_csn", 64'(dev_csn), 64'hF);
        chk("bad_code_busy", 64'(busy), 1);
        #50;
        host_csn = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bad_code_busy_release", 64'(ok), 1);
        align();
        #200;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        dev_sdo = 4'hF;
        #20;
        chk("rst_csn", 64'(dev_csn), 64'hF);
        chk("rst_ldacn", 64'(dev_ldacn), 64'hF);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_sel_err", 64'(sel_err), 0);
        chk("rst_xfer_done", 64'(xfer_done), 0);
        chk("rst_cur_sel", 64'(cur_sel), 0);
        align();
        sys_rst = 1'b0;
        #100;
        chk("idle_sdo", 64'(host_sdo), 0);

        // device 0, 32 bits, no LDAC
        push_xfer(0, 32, 64'hA5A5_0F0F);
        dev_sdo = 4'b0100;
        frame_start();
        sck_bits(64'h01, 8);
        sck_bits(64'hA5A5, 16);
        chk("dev0_sdo_other", 64'(host_sdo), 0);
        dev_sdo = 4'b0001;
        #10;
        chk("dev0_sdo_own", 64'(host_sdo), 1);
        chk("dev0_busy", 64'(busy), 1);
        chk("dev0_csn_low", 64'(dev_csn), 64'hE);
        sck_bits(64'h0F0F, 16);
        #200;
        chk("dev0_csn_before_host", 64'(dev_csn), 64'hF);
        frame_end();

        // device 2, 24 bits, LDAC, extra SCKs afterwards
        push_xfer(2, 24, 64'h12_3456);
        push_ldac(2, 4);
        dev_sdo = 4'b0100;
        frame_start();
        sck_bits(64'h03, 8);
        sck_bits(64'h123, 12);
        chk("dev2_sdo", 64'(host_sdo), 1);
        sck_bits(64'h456, 12);
        sck_bits(64'hF, 4);
        chk("dev2_extra_csn", 64'(dev_csn), 64'hF);
        frame_end();

        // device 3, 24 bits, LDAC
        push_xfer(3, 24, 64'hC0_FFEE);
        push_ldac(3, 4);
        frame_start();
        sck_bits(64'h04, 8);
        sck_bits(64'hC0FFEE, 24);
        frame_end();

        bad_code(8'h00);
        bad_code(8'h05);

        // early termination after 10 payload bits
        push_xfer(0, 10, 64'h2AB);
        frame_start();
        sck_bits(64'h01, 8);
        sck_bits(64'h2AB, 10);
        #50;
        host_csn = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (dev_csn[0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("early_csn_release", 64'(ok), 1);
        align();
        #200;

        // abort inside the select byte
        frame_start();
        sck_bits(64'h01, 5);
        host_csn = 1'b1;
        #300;
        chk("abort_csn", 64'(dev_csn), 64'hF);
        chk("abort_busy", 64'(busy), 0);

        // reset during ACTIVE on device 1, host CS# still low at release
        frame_start();
        sck_bits(64'h02, 8);
        sck_bits(64'h155, 10);
        chk("mid_csn_low", 64'(dev_csn), 64'hD);
        sys_rst = 1'b1;
        #1;
        chk("mid_rst_csn", 64'(dev_csn), 64'hF);
        chk("mid_rst_ldacn", 64'(dev_ldacn), 64'hF);
        #30;
        align();
        sys_rst = 1'b0;
        #100;
        chk("rel_low_csn_busy", 64'(busy), 0);
        host_csn = 1'b1;
        #200;

        push_xfer(1, 32, 64'hDEAD_BEEF);
        frame_start();
        sck_bits(64'h02, 8);
        sck_bits(64'hDEADBEEF, 32);
        frame_end();

        #500;
        chk("pending_events", 64'(exp_q.size()), 0);
        chk("pending_ldac", 64'(ldac_q.size()), 0);
        chk("onehot_violations", 64'(onehot_viol), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
